// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - three-stage post-add normalizer: one-hot encode, shift/exponent adjust, IEEE-754 pack.
// Valid-only pipeline; data registers load only with their stage valid, so outputs hold between results.
module fp_normalizer #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           valid_in,
  input  logic                           sign_in,
  input  logic [EXP_WIDTH-1:0]           exp_in,
  input  logic [MAN_WIDTH+1:0]           man_in,
  input  logic [MAN_WIDTH+1:0]           onehot_in,
  output logic                           valid_out,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_data,
  output logic                           zero_out,
  output logic                           ovf_out,
  output logic                           unf_out
);

  localparam int MW  = MAN_WIDTH + 2;
  localparam int PW  = $clog2(MW);
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;

  // Stage 1: leading-one position, zero and special markers
  logic [PW-1:0]        pos_d;
  logic                 zero_d;
  logic                 special_d;

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic [EXP_WIDTH-1:0] s1_exp_q;
  logic [MW-1:0]        s1_man_q;
  logic [PW-1:0]        s1_pos_q;
  logic                 s1_zero_q;
  logic                 s1_special_q;

  // Ascending scan, so a malformed vector resolves to its highest set bit.
  always_comb begin
    pos_d = '0;
    for (int i = 0; i < MW; i++) begin
      if (onehot_in[i]) pos_d = PW'(i);
    end
  end

  assign zero_d    = ~|onehot_in;
  assign special_d = &exp_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_man_q     <= '0;
      s1_pos_q     <= '0;
      s1_zero_q    <= 1'b0;
      s1_special_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_sign_q    <= sign_in;
        s1_exp_q     <= exp_in;
        s1_man_q     <= man_in;
        s1_pos_q     <= pos_d;
        s1_zero_q    <= zero_d;
        s1_special_q <= special_d;
      end
    end
  end

  // Stage 2: align leading one onto the hidden-bit position
  logic [PW-1:0]         shamt;
  logic [MW-1:0]         man_sh_d;
  logic signed [EW2-1:0] e_d;

  logic                  s2_valid_q;
  logic                  s2_sign_q;
  logic [MAN_WIDTH-1:0]  s2_frac_q;
  logic [MAN_WIDTH-1:0]  s2_raw_q;
  logic signed [EW2-1:0] s2_e_q;
  logic                  s2_zero_q;
  logic                  s2_special_q;

  assign shamt = PW'(MAN_WIDTH) - s1_pos_q;

  always_comb begin
    man_sh_d = '0;
    if (s1_pos_q == PW'(MAN_WIDTH + 1)) begin
      man_sh_d = s1_man_q >> 1;
    end else begin
      man_sh_d = s1_man_q << shamt;
    end
  end

  // e = exp + p - MAN_WIDTH covers both the carry (+1) and left-shift cases.
  assign e_d = EW2'({2'b00, s1_exp_q}) + EW2'(s1_pos_q) - EW2'(MAN_WIDTH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_frac_q    <= '0;
      s2_raw_q     <= '0;
      s2_e_q       <= '0;
      s2_zero_q    <= 1'b0;
      s2_special_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q    <= s1_sign_q;
        s2_frac_q    <= man_sh_d[MAN_WIDTH-1:0];
        s2_raw_q     <= s1_man_q[MAN_WIDTH-1:0];
        s2_e_q       <= e_d;
        s2_zero_q    <= s1_zero_q;
        s2_special_q <= s1_special_q;
      end
    end
  end

  // Stage 3: pack with special > zero > overflow > underflow > normal priority
  logic [EXP_WIDTH+MAN_WIDTH:0] data_d;
  logic                         zero_f_d;
  logic                         ovf_f_d;
  logic                         unf_f_d;

  logic                         valid_out_q;
  logic [EXP_WIDTH+MAN_WIDTH:0] data_q;
  logic                         zero_q;
  logic                         ovf_q;
  logic                         unf_q;

  always_comb begin
    data_d   = '0;
    zero_f_d = 1'b0;
    ovf_f_d  = 1'b0;
    unf_f_d  = 1'b0;
    if (s2_special_q) begin
      data_d = {s2_sign_q, {EXP_WIDTH{1'b1}}, s2_raw_q};
    end else if (s2_zero_q) begin
      data_d   = {s2_sign_q, {(EXP_WIDTH + MAN_WIDTH){1'b0}}};
      zero_f_d = 1'b1;
    end else if (s2_e_q >= E_MAX) begin
      data_d  = {s2_sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      ovf_f_d = 1'b1;
    end else if (s2_e_q <= E_ZERO) begin
      data_d  = {s2_sign_q, {(EXP_WIDTH + MAN_WIDTH){1'b0}}};
      unf_f_d = 1'b1;
    end else begin
      data_d = {s2_sign_q, s2_e_q[EXP_WIDTH-1:0], s2_frac_q};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out_q <= 1'b0;
      data_q      <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      valid_out_q <= s2_valid_q;
      if (s2_valid_q) begin
        data_q <= data_d;
        zero_q <= zero_f_d;
        ovf_q  <= ovf_f_d;
        unf_q  <= unf_f_d;
      end
    end
  end

  assign valid_out = valid_out_q;
  assign out_data  = data_q;
  assign zero_out  = zero_q;
  assign ovf_out   = ovf_q;
  assign unf_out   = unf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - randomized and directed self-check of fp_normalizer against an arithmetic reference model.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_in;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] man_in;
  logic [24:0] onehot_in;
  logic        valid_out;
  logic [31:0] out_data;
  logic        zero_out;
  logic        ovf_out;
  logic        unf_out;

  always #5 clk = ~clk;

  fp_normalizer #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .sign_in(sign_in), .exp_in(exp_in),
    .man_in(man_in), .onehot_in(onehot_in), .valid_out(valid_out), .out_data(out_data),
    .zero_out(zero_out), .ovf_out(ovf_out), .unf_out(unf_out)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [2:0]  f;   // {zero, ovf, unf}
  } res_t;

  res_t pipe [4];
  res_t held;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic res_t model(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [24:0] oh);
    res_t   r;
    int     p;
    int     ex;
    longint mag;
    r = '0;
    r.v = 1'b1;
    p = -1;
    for (int i = 0; i < 25; i++) if (oh[i]) p = i;
    if (e == 8'd255) begin
      r.d = {s, 8'hFF, m[22:0]};
    end else if (p < 0) begin
      r.d = {s, 31'd0};
      r.f = 3'b100;
    end else begin
      mag = longint'(m);
      if (p == 24) mag = mag / 2;
      else mag = mag * (longint'(1) << (23 - p));
      ex = int'(e) + p - 23;
      if (ex >= 255) begin
        r.d = {s, 8'hFF, 23'd0};
        r.f = 3'b010;
      end else if (ex <= 0) begin
        r.d = {s, 31'd0};
        r.f = 3'b001;
      end else begin
        r.d = {s, ex[7:0], 23'(mag % (longint'(1) << 23))};
      end
    end
    return r;
  endfunction

  // Drive one cycle; compare the result of the input driven three cycles earlier.
  task automatic cycle(input logic v, input logic s, input logic [7:0] e, input logic [24:0] m,
                       input logic [24:0] oh, input logic has_ref, input logic [31:0] rd, input logic [2:0] rf);
    res_t x;
    valid_in  = v;
    sign_in   = s;
    exp_in    = e;
    man_in    = m;
    onehot_in = oh;
    if (has_ref) x = '{v: 1'b1, d: rd, f: rf};
    else x = model(s, e, m, oh);
    x.v = v;
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = x;
    @(negedge clk);
    check("valid_out", {31'd0, valid_out}, {31'd0, pipe[3].v});
    if (pipe[3].v) held = pipe[3];
    check("out_data", out_data, held.d);
    check("flags", {29'd0, zero_out, ovf_out, unf_out}, {29'd0, held.f});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'($urandom), 8'($urandom), 25'($urandom), 25'($urandom), 1'b0, 32'd0, 3'd0);
  endtask

  task automatic rand_op(input logic v);
    logic [24:0] m;
    logic [24:0] oh;
    logic [7:0]  e;
    int          p;
    int          r;
    m = 25'($urandom);
    r = $urandom_range(0, 9);
    if (r == 0) m = '0;
    else if (r <= 3) m = m >> $urandom_range(0, 24);
    oh = '0;
    p  = -1;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    if (p >= 0) begin
      oh[p] = 1'b1;
      if ($urandom_range(0, 7) == 0) oh[$urandom_range(0, p)] = 1'b1;
    end
    r = $urandom_range(0, 7);
    if (r == 0) e = 8'hFF;
    else if (r == 1) e = 8'($urandom_range(0, 24));
    else if (r == 2) e = 8'($urandom_range(230, 254));
    else e = 8'($urandom_range(0, 254));
    cycle(v, 1'($urandom), e, m, oh, 1'b0, 32'd0, 3'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_flags"}, {29'd0, zero_out, ovf_out, unf_out}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; valid_in = 1'b0; sign_in = 1'b0; exp_in = '0; man_in = '0; onehot_in = '0;
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    held = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // directed vectors with hand-computed results
    cycle(1'b1, 1'b0, 8'd127, 25'h0800000, 25'h0800000, 1'b1, 32'h3F800000, 3'b000);
    cycle(1'b1, 1'b0, 8'd127, 25'h1800001, 25'h1000000, 1'b1, 32'h40400000, 3'b000);
    cycle(1'b1, 1'b0, 8'd127, 25'h0000001, 25'h0000001, 1'b1, 32'h34000000, 3'b000);
    cycle(1'b1, 1'b1, 8'd10,  25'h0000001, 25'h0000001, 1'b1, 32'h80000000, 3'b001);
    cycle(1'b1, 1'b1, 8'd254, 25'h1000000, 25'h1000000, 1'b1, 32'hFF800000, 3'b010);
    cycle(1'b1, 1'b1, 8'd100, 25'h0000000, 25'h0000000, 1'b1, 32'h80000000, 3'b100);
    cycle(1'b1, 1'b0, 8'hFF,  25'h0400001, 25'h0400000, 1'b1, 32'h7FC00001, 3'b000);
    // e lands exactly on 1 (normal) and 0 (underflow)
    cycle(1'b1, 1'b0, 8'd24,  25'h0000001, 25'h0000001, 1'b1, 32'h00800000, 3'b000);
    cycle(1'b1, 1'b0, 8'd23,  25'h0000001, 25'h0000001, 1'b1, 32'h00000000, 3'b001);
    // protocol violation: two bits set, bit 23 wins
    cycle(1'b1, 1'b0, 8'd127, 25'h0C00000, 25'h0800100, 1'b1, 32'h3FC00000, 3'b000);
    repeat (4) idle();

    // 6 back-to-back, 2 idle, 2 more
    repeat (6) rand_op(1'b1);
    repeat (2) idle();
    repeat (2) rand_op(1'b1);
    repeat (5) idle();

    for (int n = 0; n < 400; n++) rand_op($urandom_range(0, 3) != 0);
    repeat (4) idle();

    // reset pulse with two operands in flight
    rand_op(1'b1);
    rand_op(1'b1);
    rstn = 1'b0;
    valid_in = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    held = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) idle();
    check_all_zero("post_reset");

    // first operand after release still has 3-cycle latency
    cycle(1'b1, 1'b0, 8'd127, 25'h0800000, 25'h0800000, 1'b1, 32'h3F800000, 3'b000);
    repeat (4) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
